shift_pipe_ctrl: RTL and testbench



---
 rtl/shift_pipe_ctrl_pkg.sv | 18 +
 rtl/shift_pipe_ctrl_if.sv | 35 +++
 rtl/shift_reg.sv | 28 ++
 rtl/shift_pipe_ctrl.sv | 102 ++++++++++
 tb/tb_shift_pipe_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pipe_ctrl_pkg.sv
// shift_pipe_ctrl_pkg
//   Shared types and helpers for the shift_pipe_ctrl delay-line controller.
//   - state_e : controller FSM encoding (IDLE = 0, ACTIVE = 1, FLUSH = 2)
//   - occ_w   : width of the occupancy counter for a given depth
package shift_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } state_e;

    // Counter must hold the value DEPTH itself, hence DEPTH+1 codes.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/shift_pipe_ctrl_if.sv
// shift_pipe_ctrl_if
//   Stream and status bundle for shift_pipe_ctrl.
//   Upstream  : in_valid, in_ready, in_data
//   Downstream: out_valid, out_ready, out_data
//   Control   : flush (request), occupancy and idle (status)
//   master = the environment around the controller, slave = the controller.
interface shift_pipe_ctrl_if #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 128
);
    import shift_pipe_ctrl_pkg::*;

    localparam int OCC_W = occ_w(DEPTH);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  flush;
    logic [OCC_W-1:0]      occupancy;
    logic                  idle;

    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data, occupancy, idle
    );

    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data, occupancy, idle
    );

endinterface

// File: rtl/shift_reg.sv
// shift_reg
//   Enable-gated data delay line of CLOCK_CYCLES stages, no reset.
//   clk      : rising-edge clock
//   enable   : advance the whole line by one stage
//   data_in  : value captured into stage 0
//   data_out : value of the last stage
module shift_reg #(
    parameter int CLOCK_CYCLES = 8,
    parameter int DATA_WIDTH   = 128
) (
    input  logic                  clk,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [CLOCK_CYCLES-1:0][DATA_WIDTH-1:0] line_q;

    // Payload needs no reset: validity is tracked separately by the controller.
    always_ff @(posedge clk) begin
        if (enable) begin
            line_q <= {line_q[CLOCK_CYCLES-2:0], data_in};
        end
    end

    assign data_out = line_q[CLOCK_CYCLES-1];

endmodule

// File: rtl/shift_pipe_ctrl.sv
// shift_pipe_ctrl
//   Valid/ready controller for a fixed-depth delay line. Keeps one valid bit
//   per stage, derives a single shift enable from downstream back-pressure,
//   counts beats in flight and supports a one-cycle registered flush.
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : stream/status bundle (slave side), see shift_pipe_ctrl_if
module shift_pipe_ctrl
    import shift_pipe_ctrl_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 128
) (
    input  logic               clk,
    input  logic               rstn,
    shift_pipe_ctrl_if.slave   bus
);

    localparam int OCC_W = occ_w(DEPTH);

    state_e           state_q, state_d;
    logic [DEPTH-1:0] v_q, v_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             in_flush;
    logic             shift_en;
    logic             accept;
    logic             fire;

    // The whole line moves as one: it may advance whenever the last stage is
    // empty or is being drained. Bubbles travel with the data.
    always_comb begin
        in_flush = (state_q == FLUSH);
        shift_en = (~v_q[DEPTH-1] | bus.out_ready) & ~in_flush;
        accept   = bus.in_valid & shift_en;
        fire     = v_q[DEPTH-1] & bus.out_ready & ~in_flush;
    end

    always_comb begin
        v_d = v_q;
        if (in_flush) begin
            v_d = '0;
        end else if (shift_en) begin
            v_d = {v_q[DEPTH-2:0], bus.in_valid};
        end
    end

    // Accept and fire in the same cycle cancel, so a full line that is
    // streaming stays at DEPTH.
    always_comb begin
        occ_d = occ_q;
        if (in_flush) begin
            occ_d = '0;
        end else if (accept && !fire) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (fire && !accept) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // IDLE/ACTIVE simply mirror whether the next occupancy is zero; flush
    // takes priority and FLUSH always returns to IDLE since the line is empty.
    always_comb begin
        state_d = state_q;
        if (in_flush) begin
            state_d = IDLE;
        end else if (bus.flush) begin
            state_d = FLUSH;
        end else if (occ_d != '0) begin
            state_d = ACTIVE;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            v_q     <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            occ_q   <= occ_d;
        end
    end

    assign bus.in_ready  = shift_en;
    assign bus.out_valid = v_q[DEPTH-1] & ~in_flush;
    assign bus.occupancy = occ_q;
    assign bus.idle      = (state_q == IDLE);

    shift_reg #(
        .CLOCK_CYCLES (DEPTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_line (
        .clk      (clk),
        .enable   (shift_en),
        .data_in  (bus.in_data),
        .data_out (bus.out_data)
    );

endmodule

// File: tb/tb_shift_pipe_ctrl.sv
// tb_shift_pipe_ctrl
//   Directed and random stimulus for shift_pipe_ctrl. Every cycle the outputs
//   are compared with a scoreboard: accepted beats are pushed with a stage
//   position, advanced on each expected shift, and popped on output fire.
module tb_shift_pipe_ctrl;

    localparam int DEPTH = 8;
    localparam int DW    = 128;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    shift_pipe_ctrl_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus_if ();

    shift_pipe_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_emit = 0;

    // Scoreboard: per beat, its stage index and payload.
    int            pos_q[$];
    logic [DW-1:0] dat_q[$];
    bit            m_flush = 1'b0;

    // Values sampled in the most recent step.
    logic       s_ov, s_ir, s_idle;
    logic [3:0] s_occ;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl);
        bus_if.in_valid  = iv;
        bus_if.in_data   = d;
        bus_if.out_ready = ordy;
        bus_if.flush     = fl;
    endtask

    task automatic model_reset();
        pos_q.delete();
        dat_q.delete();
        m_flush = 1'b0;
    endtask

    // One clock: sample and check outputs, update scoreboard, take the edge.
    task automatic step();
        bit e_ov, e_ir, e_idle, fire;
        int p;
        logic [DW-1:0] d;
        #1;
        s_ov   = bus_if.out_valid;
        s_ir   = bus_if.in_ready;
        s_occ  = bus_if.occupancy;
        s_idle = bus_if.idle;
        e_ov   = !m_flush && (pos_q.size() > 0) && (pos_q[0] == DEPTH - 1);
        e_ir   = !m_flush && (!e_ov || bus_if.out_ready);
        e_idle = !m_flush && (dat_q.size() == 0);
        chk("out_valid", DW'(s_ov), DW'(e_ov));
        chk("in_ready",  DW'(s_ir), DW'(e_ir));
        chk("occupancy", DW'(s_occ), DW'(dat_q.size()));
        chk("idle",      DW'(s_idle), DW'(e_idle));
        fire = e_ov && bus_if.out_ready;
        if (fire) begin
            chk("out_data", bus_if.out_data, dat_q[0]);
            n_emit++;
        end
        if (m_flush) begin
            model_reset();
        end else begin
            if (e_ir) begin
                if (fire) begin
                    p = pos_q.pop_front();
                    d = dat_q.pop_front();
                end
                foreach (pos_q[i]) pos_q[i]++;
                if (bus_if.in_valid) begin
                    pos_q.push_back(0);
                    dat_q.push_back(bus_if.in_data);
                end
            end
            m_flush = bus_if.flush;
        end
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic drain();
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 4 * DEPTH && dat_q.size() > 0; k++) step();
        step();
        chk("drain_idle", DW'(s_idle), DW'(1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_acc, first_ov, peak, cnt;
        bit in_pat[40];
        bit ov_pat[40];

        // Reset state
        drive(1'b0, '0, 1'b1, 1'b0);
        rstn = 1'b0;
        #3;
        chk("rst_out_valid", DW'(bus_if.out_valid), DW'(0));
        chk("rst_in_ready",  DW'(bus_if.in_ready),  DW'(1));
        chk("rst_idle",      DW'(bus_if.idle),      DW'(1));
        chk("rst_occ",       DW'(bus_if.occupancy), DW'(0));
        @(posedge clk);
        #2;
        rstn = 1'b1;
        model_reset();

        // Stream 20 beats, no back-pressure
        first_acc = -1; first_ov = -1; peak = 0; n_emit = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, DW'(i), 1'b1, 1'b0);
            step();
            if (s_ir && first_acc < 0) first_acc = cyc - 1;
            if (s_ov && first_ov < 0) first_ov = cyc - 1;
            if (int'(s_occ) > peak) peak = int'(s_occ);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 4 * DEPTH && dat_q.size() > 0; k++) begin
            step();
            if (s_ov && first_ov < 0) first_ov = cyc - 1;
        end
        step();
        chk("stream_idle_after", DW'(s_idle), DW'(1));
        chk("stream_latency", DW'(first_ov - first_acc), DW'(8));
        chk("stream_peak_occ", DW'(peak), DW'(8));
        chk("stream_emit_count", DW'(n_emit), DW'(20));

        // Fill with back-pressure, then stream through a full line
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, DW'(100 + i), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, DW'(200), 1'b0, 1'b0);
        step();
        chk("full_in_ready", DW'(s_ir), DW'(0));
        chk("full_occ", DW'(s_occ), DW'(8));
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, DW'(300 + i), 1'b1, 1'b0);
            step();
            chk("full_thru_occ", DW'(s_occ), DW'(8));
        end
        drain();

        // Alternating input: bubbles preserved, pattern delayed by DEPTH
        for (int k = 0; k < 40; k++) begin
            in_pat[k] = (k < 24) && (k % 2 == 0);
            drive(in_pat[k], DW'(500 + k), 1'b1, 1'b0);
            step();
            ov_pat[k] = s_ov;
        end
        for (int k = 0; k < 32; k++) begin
            chk("bubble_pattern", DW'(ov_pat[k]), DW'((k >= DEPTH) ? in_pat[k - DEPTH] : 1'b0));
        end
        drain();

        // Flush with five beats in flight
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, DW'(700 + i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        step();
        chk("flush_req_occ", DW'(s_occ), DW'(5));
        drive(1'b1, DW'(999), 1'b1, 1'b0);
        step();
        chk("flush_in_ready", DW'(s_ir), DW'(0));
        chk("flush_out_valid", DW'(s_ov), DW'(0));
        chk("flush_not_idle", DW'(s_idle), DW'(0));
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        chk("flush_exit_occ", DW'(s_occ), DW'(0));
        chk("flush_exit_idle", DW'(s_idle), DW'(1));
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (s_ov) cnt++;
        end
        chk("flush_no_stale", DW'(cnt), DW'(0));

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, DW'(800 + i), 1'b1, 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        rstn = 1'b0;
        #1;
        chk("midrst_out_valid", DW'(bus_if.out_valid), DW'(0));
        chk("midrst_occ", DW'(bus_if.occupancy), DW'(0));
        chk("midrst_idle", DW'(bus_if.idle), DW'(1));
        model_reset();
        @(posedge clk);
        #2;
        rstn = 1'b1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (s_ov) cnt++;
        end
        chk("midrst_no_stale", DW'(cnt), DW'(0));

        // Random traffic against the scoreboard
        for (int k = 0; k < 10000; k++) begin
            drive(1'($urandom_range(0, 1)),
                  {$urandom(), $urandom(), $urandom(), $urandom()},
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 199) == 0));
            step();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
